pixel_pair_source: RTL and testbench
====================================

// Module: pixel_pair_source
// PURPOSE
//   Producer side of the ALT per-pixel stream. Takes the DVI and CCD RGB565 pixel streams
//   (valid/ready, start-of-frame marked) and buffers each one. Aligns the two streams on
//   start-of-frame and pairs them one-to-one. Emits one paired beat per cycle with raster
//   coordinates as valid_o/syncX_o/syncY_o/DVI_*_o/CCD_*_o for the ambient-light threshold block.
// PARAMETERS
//   H_ACTIVE    640  active pixels per line; syncX_o range 0..H_ACTIVE-1
//   V_ACTIVE    480  active lines per frame; syncY_o range 0..V_ACTIVE-1
//   FIFO_AW     4    per-stream FIFO address width; depth = 2**FIFO_AW (16)
// PORTS
//   clk_pixl     in   1   pixel clock; all logic in this domain
//   reset        in   1   asynchronous, active-low
//   enable       in   1   level; 0 = idle/flush, 1 = run
//   dvi_valid_i  in   1   DVI beat present
//   dvi_sof_i    in   1   DVI beat is pixel (0,0) of a frame
//   dvi_pix_i    in   16  DVI RGB565 {R[15:11],G[10:5],B[4:0]}
//   dvi_ready_o  out  1   DVI beat accepted when valid&ready
//   ccd_valid_i  in   1   CCD beat present
//   ccd_sof_i    in   1   CCD start-of-frame
//   ccd_pix_i    in   16  CCD RGB565, same packing
//   ccd_ready_o  out  1   CCD beat accepted when valid&ready
//   valid_o      out  1   paired beat valid (no backpressure downstream)
//   syncX_o      out  10  column of paired beat
//   syncY_o      out  10  line of paired beat
//   DVI_R_o/DVI_G_o/DVI_B_o  out 5/6/5  unpacked DVI pixel
//   CCD_R_o/CCD_G_o/CCD_B_o  out 5/6/5  unpacked CCD pixel
//   frame_done_o out  1   pulse with beat (H_ACTIVE-1,V_ACTIVE-1)
//   sync_err_o   out  1   one-cycle pulse on misaligned sof
//   frame_cnt_o  out  16  completed frames, wraps at 16'hFFFF->0
// BEHAVIOUR
//   Reset: every registered output 0; FSM=IDLE; FIFOs empty; arm flags 0; X/Y counters 0.
//   FSM IDLE: ready_o=1 on both inputs, all beats dropped. Leaves to WAIT_SOF when enable=1.
//   FSM WAIT_SOF: per stream, a beat is written only if sof=1 or that stream's arm flag is set.
//     Writing a sof beat sets the arm flag. Non-sof unarmed beats are accepted and dropped.
//     Goes to STREAM when both FIFOs are non-empty and both heads carry sof.
//   FSM STREAM: armed streams write every accepted beat. ready_o = !full (ignores same-cycle pop).
//     Pop both FIFOs in the same cycle only when both are non-empty; never pop one alone.
//   Check on each pop: (sof_dvi|sof_ccd) must equal (X==0 && Y==0), and sof_dvi must equal sof_ccd.
//     On mismatch: no valid_o, sync_err_o=1 next cycle, flush both FIFOs, clear arm flags,
//     X=Y=0, go to WAIT_SOF. frame_cnt_o is unchanged.
//   Latency: pop -> registered outputs 1 cycle later. valid_o=1 for exactly one cycle per pop.
//   When valid_o=0, pixel and sync outputs hold their last values.
//   Counters: X increments per pop. At X=H_ACTIVE-1, X wraps to 0 and Y increments.
//     At (H_ACTIVE-1,V_ACTIVE-1), Y wraps to 0, frame_done_o=1 with that beat, frame_cnt_o+1.
//     FSM stays in STREAM and expects sof on the next pop.
//   Unpack: R=pix[15:11], G=pix[10:5], B=pix[4:0]. No scaling; consumer widens.
//   Same-cycle write and pop on one FIFO is legal, including at full: count stays the same.
//   enable=0 in any state: next cycle valid_o=0, FIFOs flushed, arms cleared, X=Y=0, FSM=IDLE.
//     Pulse outputs are 0; frame_cnt_o is held.
//   Asynchronous reset mid-frame returns everything to reset values immediately.
// STRUCTURE
//   Shared package alt_pkg: H_ACTIVE/V_ACTIVE defaults, RGB565 field bit positions,
//     FSM state enum {IDLE,WAIT_SOF,STREAM}, 17-bit FIFO entry layout {sof,pix[15:0]}.
//   Sub-module pix_fifo: synchronous FIFO, 17 bits wide, depth 2**FIFO_AW.
//     Ports: wr_en, rd_en, flush, full, empty, head data (show-ahead). Two instances.
//   FSM, counters, sof check and output registers live in pixel_pair_source.
// TESTING
//   Aligned streams, both sof together, 640x480 continuous
//     -> 307200 valid_o beats; last beat X=639,Y=479 with frame_done_o=1;
//        next beat X=0,Y=0; frame_cnt_o=1.
//   CCD sends 5 non-sof junk beats before its sof, DVI starts at sof
//     -> junk dropped; first valid_o at (0,0) carries both sof pixels; sync_err_o never set.
//   DVI stalls 20 cycles mid-line while CCD streams
//     -> ccd_ready_o=0 after 16 stored; valid_o gap of >=20 cycles; X continuous; no beat lost or duplicated.
//   DVI sof injected at pixel 100 of line 0
//     -> sync_err_o pulse; FIFOs empty next cycle; FSM=WAIT_SOF; frame_cnt_o unchanged;
//        recovery on next common sof.
//   enable driven 0 at X=300,Y=200, then back to 1
//     -> valid_o=0 next cycle; both ready_o=1; restart waits for sof; first beat at (0,0).
//   dvi_pix_i=16'hF81F, ccd_pix_i=16'h07E0
//     -> DVI_R_o=5'h1F, DVI_G_o=0, DVI_B_o=5'h1F, CCD_R_o=0, CCD_G_o=6'h3F, CCD_B_o=0.

Source files
------------

// File: rtl/alt_pkg.sv
// Shared definitions for the ALT per-pixel stream:
// frame geometry, RGB565 layout, pairing FSM states and FIFO entry format.
package alt_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int PIX_W = 16;
    localparam int R_HI  = 15;
    localparam int R_LO  = 11;
    localparam int G_HI  = 10;
    localparam int G_LO  = 5;
    localparam int B_HI  = 4;
    localparam int B_LO  = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        STREAM
    } state_t;

    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] pix;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/pix_fifo.sv
// Show-ahead synchronous FIFO holding {sof, pixel} entries for one stream.
// Flush empties it in one cycle; write and read together at full is allowed.
module pix_fifo #(
    parameter int W  = 17,
    parameter int AW = 4
) (
    input  logic         clk_pixl,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count == '0);
    assign full  = (count == DEPTH[AW:0]);
    assign head  = mem[rd_ptr];
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_pixl) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pixel_pair_source.sv
// Buffers the DVI and CCD pixel streams, aligns them on start-of-frame
// and emits one paired, raster-addressed beat per pop.
module pixel_pair_source
    import alt_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int FIFO_AW  = 4
) (
    input  logic        clk_pixl,
    input  logic        reset,
    input  logic        enable,
    input  logic        dvi_valid_i,
    input  logic        dvi_sof_i,
    input  logic [15:0] dvi_pix_i,
    output logic        dvi_ready_o,
    input  logic        ccd_valid_i,
    input  logic        ccd_sof_i,
    input  logic [15:0] ccd_pix_i,
    output logic        ccd_ready_o,
    output logic        valid_o,
    output logic [9:0]  syncX_o,
    output logic [9:0]  syncY_o,
    output logic [4:0]  DVI_R_o,
    output logic [5:0]  DVI_G_o,
    output logic [4:0]  DVI_B_o,
    output logic [4:0]  CCD_R_o,
    output logic [5:0]  CCD_G_o,
    output logic [4:0]  CCD_B_o,
    output logic        frame_done_o,
    output logic        sync_err_o,
    output logic [15:0] frame_cnt_o
);

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t     state;
    logic       dvi_arm;
    logic       ccd_arm;
    logic [9:0] x;
    logic [9:0] y;
    entry_t     dvi_in;
    entry_t     ccd_in;
    entry_t     dvi_head;
    entry_t     ccd_head;
    logic       dvi_full;
    logic       dvi_empty;
    logic       ccd_full;
    logic       ccd_empty;
    logic       dvi_wr;
    logic       ccd_wr;
    logic       pop;
    logic       bad;
    logic       flush;

    assign dvi_in = '{sof: dvi_sof_i, pix: dvi_pix_i};
    assign ccd_in = '{sof: ccd_sof_i, pix: ccd_pix_i};

    // IDLE swallows everything; otherwise unarmed streams are empty, so !full also drops junk
    assign dvi_ready_o = (state == IDLE) || !dvi_full;
    assign ccd_ready_o = (state == IDLE) || !ccd_full;

    assign dvi_wr = dvi_valid_i && dvi_ready_o && (state != IDLE)
                    && (dvi_sof_i || dvi_arm);
    assign ccd_wr = ccd_valid_i && ccd_ready_o && (state != IDLE)
                    && (ccd_sof_i || ccd_arm);

    assign pop = enable && (state == STREAM) && !dvi_empty && !ccd_empty;

    assign bad = ((dvi_head.sof || ccd_head.sof) != (x == '0 && y == '0))
                 || (dvi_head.sof != ccd_head.sof);

    assign flush = !enable || (pop && bad);

    pix_fifo #(.W(ENTRY_W), .AW(FIFO_AW)) u_dvi_fifo (
        .clk_pixl (clk_pixl),
        .reset    (reset),
        .wr_en    (dvi_wr),
        .wr_data  (dvi_in),
        .rd_en    (pop),
        .flush    (flush),
        .head     (dvi_head),
        .full     (dvi_full),
        .empty    (dvi_empty)
    );

    pix_fifo #(.W(ENTRY_W), .AW(FIFO_AW)) u_ccd_fifo (
        .clk_pixl (clk_pixl),
        .reset    (reset),
        .wr_en    (ccd_wr),
        .wr_data  (ccd_in),
        .rd_en    (pop),
        .flush    (flush),
        .head     (ccd_head),
        .full     (ccd_full),
        .empty    (ccd_empty)
    );

    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            dvi_arm      <= 1'b0;
            ccd_arm      <= 1'b0;
            x            <= '0;
            y            <= '0;
            valid_o      <= 1'b0;
            syncX_o      <= '0;
            syncY_o      <= '0;
            DVI_R_o      <= '0;
            DVI_G_o      <= '0;
            DVI_B_o      <= '0;
            CCD_R_o      <= '0;
            CCD_G_o      <= '0;
            CCD_B_o      <= '0;
            frame_done_o <= 1'b0;
            sync_err_o   <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
            sync_err_o   <= 1'b0;
            if (flush) begin
                dvi_arm <= 1'b0;
                ccd_arm <= 1'b0;
            end else begin
                dvi_arm <= dvi_arm || (dvi_wr && dvi_sof_i);
                ccd_arm <= ccd_arm || (ccd_wr && ccd_sof_i);
            end
            if (!enable) begin
                state <= IDLE;
                x     <= '0;
                y     <= '0;
            end else begin
                unique case (state)
                    IDLE: state <= WAIT_SOF;
                    WAIT_SOF: begin
                        if (!dvi_empty && !ccd_empty
                            && dvi_head.sof && ccd_head.sof)
                            state <= STREAM;
                    end
                    STREAM: begin
                        if (pop && bad) begin
                            sync_err_o <= 1'b1;
                            x          <= '0;
                            y          <= '0;
                            state      <= WAIT_SOF;
                        end else if (pop) begin
                            valid_o <= 1'b1;
                            syncX_o <= x;
                            syncY_o <= y;
                            DVI_R_o <= dvi_head.pix[R_HI:R_LO];
                            DVI_G_o <= dvi_head.pix[G_HI:G_LO];
                            DVI_B_o <= dvi_head.pix[B_HI:B_LO];
                            CCD_R_o <= ccd_head.pix[R_HI:R_LO];
                            CCD_G_o <= ccd_head.pix[G_HI:G_LO];
                            CCD_B_o <= ccd_head.pix[B_HI:B_LO];
                            if (x == X_LAST) begin
                                x <= '0;
                                if (y == Y_LAST) begin
                                    y            <= '0;
                                    frame_done_o <= 1'b1;
                                    frame_cnt_o  <= frame_cnt_o + 16'd1;
                                end else begin
                                    y <= y + 10'd1;
                                end
                            end else begin
                                x <= x + 10'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_pair_source.sv
// Scoreboard bench for pixel_pair_source on a small 8x4 raster.
// Drivers replay per-stream beat queues; a monitor checks every paired beat.
module tb_pixel_pair_source;

    localparam int H = 8;
    localparam int V = 4;
    localparam int F = H * V;

    logic        clk_pixl = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        dvi_valid_i = 1'b0;
    logic        dvi_sof_i = 1'b0;
    logic [15:0] dvi_pix_i = 16'h0;
    logic        dvi_ready_o;
    logic        ccd_valid_i = 1'b0;
    logic        ccd_sof_i = 1'b0;
    logic [15:0] ccd_pix_i = 16'h0;
    logic        ccd_ready_o;
    logic        valid_o;
    logic [9:0]  syncX_o;
    logic [9:0]  syncY_o;
    logic [4:0]  DVI_R_o;
    logic [5:0]  DVI_G_o;
    logic [4:0]  DVI_B_o;
    logic [4:0]  CCD_R_o;
    logic [5:0]  CCD_G_o;
    logic [4:0]  CCD_B_o;
    logic        frame_done_o;
    logic        sync_err_o;
    logic [15:0] frame_cnt_o;

    typedef struct {
        int          gap;
        bit          sof;
        logic [15:0] pix;
    } beat_t;

    typedef struct {
        int x, y, dr, dg, db, cr, cg, cb;
        bit done;
    } exp_t;

    beat_t dvi_q[$];
    beat_t ccd_q[$];
    exp_t  exp_q[$];

    int errors = 0;
    int checks = 0;
    int mpos = 0;
    int m_frames = 0;
    int exp_err = 0;
    int err_seen = 0;
    int gap_cnt = 0;
    int max_gap = 0;
    bit dvi_busy = 0;
    bit ccd_busy = 0;
    bit dvi_gap_on = 0;

    pixel_pair_source #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_AW(4)) dut (
        .clk_pixl     (clk_pixl),
        .reset        (reset),
        .enable       (enable),
        .dvi_valid_i  (dvi_valid_i),
        .dvi_sof_i    (dvi_sof_i),
        .dvi_pix_i    (dvi_pix_i),
        .dvi_ready_o  (dvi_ready_o),
        .ccd_valid_i  (ccd_valid_i),
        .ccd_sof_i    (ccd_sof_i),
        .ccd_pix_i    (ccd_pix_i),
        .ccd_ready_o  (ccd_ready_o),
        .valid_o      (valid_o),
        .syncX_o      (syncX_o),
        .syncY_o      (syncY_o),
        .DVI_R_o      (DVI_R_o),
        .DVI_G_o      (DVI_G_o),
        .DVI_B_o      (DVI_B_o),
        .CCD_R_o      (CCD_R_o),
        .CCD_G_o      (CCD_G_o),
        .CCD_B_o      (CCD_B_o),
        .frame_done_o (frame_done_o),
        .sync_err_o   (sync_err_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    always #5 clk_pixl = ~clk_pixl;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic set_in(input bit c, input bit v, input bit s,
                          input logic [15:0] p);
        if (c) begin
            ccd_valid_i = v; ccd_sof_i = s; ccd_pix_i = p;
        end else begin
            dvi_valid_i = v; dvi_sof_i = s; dvi_pix_i = p;
        end
    endtask

    // Holds each beat until accepted, so the delivered order equals queue order
    task automatic drive(input bit c);
        beat_t b;
        bit    acc;
        int    n;
        forever begin
            if ((c ? ccd_q.size() : dvi_q.size()) == 0) begin
                set_in(c, 1'b0, 1'b0, 16'h0);
                @(posedge clk_pixl); #1;
            end else begin
                if (c) begin
                    b = ccd_q.pop_front(); ccd_busy = 1;
                end else begin
                    b = dvi_q.pop_front(); dvi_busy = 1;
                end
                set_in(c, 1'b0, 1'b0, 16'h0);
                for (int i = 0; i < b.gap; i++) begin
                    if (!c) dvi_gap_on = 1;
                    @(posedge clk_pixl); #1;
                end
                if (!c) dvi_gap_on = 0;
                set_in(c, 1'b1, b.sof, b.pix);
                acc = 0;
                n = 0;
                while (!acc && n < 500) begin
                    @(negedge clk_pixl);
                    acc = c ? ccd_ready_o : dvi_ready_o;
                    @(posedge clk_pixl); #1;
                    n++;
                end
                if (!acc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_accept: ready low for %0d cycles, want high",
                             c ? "ccd" : "dvi", n);
                end
                set_in(c, 1'b0, 1'b0, 16'h0);
                if (c) ccd_busy = 0;
                else dvi_busy = 0;
            end
        end
    endtask

    initial drive(1'b0);
    initial drive(1'b1);

    task automatic push_pair(input bit sd, input bit sc,
                             input logic [15:0] pd, input logic [15:0] pc,
                             input int gd, input int gc, input bit keep);
        exp_t e;
        dvi_q.push_back('{gap: gd, sof: sd, pix: pd});
        ccd_q.push_back('{gap: gc, sof: sc, pix: pc});
        if (keep) begin
            e.x    = mpos % H;
            e.y    = (mpos / H) % V;
            e.dr   = int'(pd) / 2048;
            e.dg   = (int'(pd) / 32) % 64;
            e.db   = int'(pd) % 32;
            e.cr   = int'(pc) / 2048;
            e.cg   = (int'(pc) / 32) % 64;
            e.cb   = int'(pc) % 32;
            e.done = (mpos % F) == F - 1;
            exp_q.push_back(e);
            mpos++;
            if (e.done) m_frames++;
        end
    endtask

    task automatic send_frames(input int n, input int gmax, input int stall_k,
                               input bit special);
        logic [15:0] pd;
        logic [15:0] pc;
        int          gd;
        mpos = 0;
        for (int k = 0; k < n * F; k++) begin
            pd = 16'($urandom);
            pc = 16'($urandom);
            if (special && k == 1) begin
                pd = 16'hF81F;
                pc = 16'h07E0;
            end
            gd = (k == stall_k) ? 24 : int'($urandom_range(gmax, 0));
            push_pair(k % F == 0, k % F == 0, pd, pc, gd,
                      int'($urandom_range(gmax, 0)), 1'b1);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || dvi_q.size() != 0 || ccd_q.size() != 0
                || dvi_busy || ccd_busy) && n < 5000) begin
            @(posedge clk_pixl);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d beats pending after %0d cycles, want 0",
                     name, exp_q.size(), n);
            exp_q.delete();
        end
        repeat (4) @(posedge clk_pixl);
    endtask

    // Monitor: every valid_o must match the next expected pair
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_pixl);
            if (sync_err_o) err_seen++;
            if (valid_o) begin
                if (gap_cnt > max_gap) max_gap = gap_cnt;
                gap_cnt = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got x=%0d y=%0d, want no beat",
                             syncX_o, syncY_o);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(syncX_o) != e.x || int'(syncY_o) != e.y
                        || int'(DVI_R_o) != e.dr || int'(DVI_G_o) != e.dg
                        || int'(DVI_B_o) != e.db || int'(CCD_R_o) != e.cr
                        || int'(CCD_G_o) != e.cg || int'(CCD_B_o) != e.cb
                        || frame_done_o != e.done) begin
                        errors++;
                        $display("FAIL beat: got x=%0d y=%0d dvi=%0d/%0d/%0d ccd=%0d/%0d/%0d done=%0d, want x=%0d y=%0d dvi=%0d/%0d/%0d ccd=%0d/%0d/%0d done=%0d",
                                 syncX_o, syncY_o, DVI_R_o, DVI_G_o, DVI_B_o,
                                 CCD_R_o, CCD_G_o, CCD_B_o, frame_done_o,
                                 e.x, e.y, e.dr, e.dg, e.db,
                                 e.cr, e.cg, e.cb, e.done);
                    end
                end
            end else begin
                gap_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int  n;
        int  fc;
        bit  hit;

        #12;
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_frame_cnt", int'(frame_cnt_o), 0);
        chk("rst_pulses", int'({sync_err_o, frame_done_o}), 0);
        chk("rst_sync", int'({syncY_o, syncX_o}), 0);
        chk("rst_pix", int'({DVI_R_o, DVI_G_o, DVI_B_o,
                             CCD_R_o, CCD_G_o, CCD_B_o}), 0);
        chk("rst_ready", int'({dvi_ready_o, ccd_ready_o}), 3);
        #10 reset = 1'b1;
        @(posedge clk_pixl); #1;
        enable = 1'b1;
        repeat (3) @(posedge clk_pixl);
        #1;

        // aligned frames with random gaps, includes the F81F/07E0 pair
        send_frames(3, 2, -1, 1'b1);
        drain("aligned");
        chk("aligned_frame_cnt", int'(frame_cnt_o), m_frames);
        chk("aligned_sync_err", err_seen, exp_err);

        // DVI stalls mid-line while CCD keeps streaming
        max_gap = 0;
        gap_cnt = 0;
        send_frames(2, 0, 12, 1'b0);
        n = 0;
        while (!dvi_gap_on && n < 2000) begin
            @(posedge clk_pixl);
            n++;
        end
        chk("stall_seen", int'(dvi_gap_on), 1);
        repeat (20) @(posedge clk_pixl);
        @(negedge clk_pixl);
        chk("stall_ccd_ready", int'(ccd_ready_o), 0);
        drain("stall");
        chk("stall_valid_gap", int'(max_gap >= 20), 1);
        chk("stall_frame_cnt", int'(frame_cnt_o), m_frames);

        // DVI sof injected mid-line
        mpos = 0;
        for (int k = 0; k < 5; k++)
            push_pair(k == 0, k == 0, 16'($urandom), 16'($urandom), 0, 0, 1'b1);
        push_pair(1'b1, 1'b0, 16'hAAAA, 16'h5555, 0, 0, 1'b0);
        exp_err++;
        drain("sof_err");
        chk("err_pulse_cnt", err_seen, exp_err);
        chk("err_frame_cnt", int'(frame_cnt_o), m_frames);
        send_frames(1, 1, -1, 1'b0);
        drain("recover");
        chk("recover_frame_cnt", int'(frame_cnt_o), m_frames);
        chk("recover_sync_err", err_seen, exp_err);

        // enable dropped at (3,2), then restart with CCD junk ahead of sof
        fc = m_frames;
        send_frames(1, 1, -1, 1'b0);
        hit = 0;
        n = 0;
        while (!hit && n < 2000) begin
            @(negedge clk_pixl);
            hit = valid_o && syncX_o == 10'd3 && syncY_o == 10'd2;
            n++;
        end
        chk("en_hit_pos", int'(hit), 1);
        #1;
        enable = 1'b0;
        exp_q.delete();
        dvi_q.delete();
        ccd_q.delete();
        m_frames = fc;
        @(posedge clk_pixl);
        @(negedge clk_pixl);
        chk("en_off_valid", int'(valid_o), 0);
        chk("en_off_ready", int'({dvi_ready_o, ccd_ready_o}), 3);
        chk("en_off_frame_cnt", int'(frame_cnt_o), m_frames);
        repeat (3) @(posedge clk_pixl);
        #1;
        enable = 1'b1;
        repeat (3) @(posedge clk_pixl);
        #1;
        for (int k = 0; k < 5; k++)
            ccd_q.push_back('{gap: 0, sof: 1'b0, pix: 16'($urandom)});
        send_frames(1, 1, -1, 1'b0);
        drain("restart");
        chk("restart_frame_cnt", int'(frame_cnt_o), m_frames);
        chk("restart_sync_err", err_seen, exp_err);

        // asynchronous reset mid-frame
        send_frames(1, 0, -1, 1'b0);
        n = 0;
        while (exp_q.size() > F - 10 && n < 2000) begin
            @(posedge clk_pixl);
            n++;
        end
        @(posedge clk_pixl);
        #2;
        exp_q.delete();
        dvi_q.delete();
        ccd_q.delete();
        reset = 1'b0;
        m_frames = 0;
        #1;
        chk("arst_valid", int'(valid_o), 0);
        chk("arst_frame_cnt", int'(frame_cnt_o), m_frames);
        chk("arst_sync", int'({syncY_o, syncX_o}), 0);
        chk("arst_ready", int'({dvi_ready_o, ccd_ready_o}), 3);
        #20 reset = 1'b1;
        repeat (5) @(posedge clk_pixl);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
